// File: rtl/ecap5_dproc_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM encoding, the reset NOP word and a PC helper.
package ecap5_dproc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        HOLD    = 2'd2,
        DROP    = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Sequential word address; wraps naturally from 32'hFFFF_FFFC to 0.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding word reads, one-entry skid slot,
// branch redirect that never presents a word fetched from the old path.
module fetch_unit
    import ecap5_dproc_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    output logic         mem_req_o,
    output logic [31:0]  mem_addr_o,
    input  logic         mem_ack_i,
    input  logic [31:0]  mem_data_i,
    input  logic         branch_i,
    input  logic [31:0]  branch_target_i,
    input  logic         stall_i,
    output logic         valid_o,
    output logic [31:0]  instr_o,
    output logic [31:0]  pc_o,
    output fetch_state_t dbg_state_o
);

    // Handshake: a request is live while mem_req_o=1 and completes at the
    // first rising edge with mem_ack_i=1; address is stable until then.
    // The output slot is consumed at an edge with valid_o=1 and stall_i=0.

    localparam logic [31:0] BOOT_ALIGNED = {BOOT_ADDRESS[31:2], 2'b00};

    fetch_state_t r_state, w_state_next;
    logic [31:0]  r_pc, w_pc_next;
    logic [31:0]  r_drop_addr, w_drop_addr_next;
    logic         r_skid_full, w_skid_full_next;
    logic [31:0]  r_skid_instr, w_skid_instr_next;
    logic [31:0]  r_skid_pc, w_skid_pc_next;
    logic         r_valid, w_valid_next;
    logic [31:0]  r_instr, w_instr_next;
    logic [31:0]  r_pc_out, w_pc_out_next;

    logic         w_slot_free;
    logic [31:0]  w_target;

    assign w_slot_free = !r_valid || !stall_i;
    assign w_target    = {branch_target_i[31:2], 2'b00};

    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_drop_addr_next  = r_drop_addr;
        w_skid_full_next  = r_skid_full;
        w_skid_instr_next = r_skid_instr;
        w_skid_pc_next    = r_skid_pc;
        w_valid_next      = r_valid;
        w_instr_next      = r_instr;
        w_pc_out_next     = r_pc_out;

        if (r_valid && !stall_i) begin
            w_valid_next = 1'b0;
        end

        case (r_state)
            IDLE: begin
                w_state_next = REQUEST;
            end
            REQUEST: begin
                if (mem_ack_i) begin
                    w_pc_next = next_pc(r_pc);
                    if (w_slot_free) begin
                        w_instr_next  = mem_data_i;
                        w_pc_out_next = r_pc;
                        w_valid_next  = 1'b1;
                    end else begin
                        w_skid_instr_next = mem_data_i;
                        w_skid_pc_next    = r_pc;
                        w_skid_full_next  = 1'b1;
                        w_state_next      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (w_slot_free) begin
                    w_instr_next     = r_skid_instr;
                    w_pc_out_next    = r_skid_pc;
                    w_valid_next     = 1'b1;
                    w_skid_full_next = 1'b0;
                    w_state_next     = REQUEST;
                end
            end
            DROP: begin
                if (mem_ack_i) begin
                    w_state_next = REQUEST;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // A redirect overrides everything above; an un-acked request is
        // allowed to finish on the bus and its data thrown away in DROP.
        if (branch_i) begin
            w_pc_next        = w_target;
            w_valid_next     = 1'b0;
            w_instr_next     = r_instr;
            w_pc_out_next    = r_pc_out;
            w_skid_full_next = 1'b0;
            case (r_state)
                REQUEST: begin
                    if (mem_ack_i) begin
                        w_state_next = REQUEST;
                    end else begin
                        w_state_next     = DROP;
                        w_drop_addr_next = r_pc;
                    end
                end
                DROP:    w_state_next = mem_ack_i ? REQUEST : DROP;
                default: w_state_next = REQUEST;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_pc         <= BOOT_ALIGNED;
            r_drop_addr  <= 32'h0;
            r_skid_full  <= 1'b0;
            r_skid_instr <= NOP_INSTR;
            r_skid_pc    <= 32'h0;
            r_valid      <= 1'b0;
            r_instr      <= NOP_INSTR;
            r_pc_out     <= 32'h0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_drop_addr  <= w_drop_addr_next;
            r_skid_full  <= w_skid_full_next;
            r_skid_instr <= w_skid_instr_next;
            r_skid_pc    <= w_skid_pc_next;
            r_valid      <= w_valid_next;
            r_instr      <= w_instr_next;
            r_pc_out     <= w_pc_out_next;
        end
    end

    assign mem_req_o   = (r_state == REQUEST) || (r_state == DROP);
    assign mem_addr_o  = (r_state == REQUEST) ? r_pc :
                         (r_state == DROP)    ? r_drop_addr : 32'h0;
    assign valid_o     = r_valid;
    assign instr_o     = r_instr;
    assign pc_o        = r_pc_out;
    assign dbg_state_o = r_state;

endmodule
